dmux_way_router: RTL and testbench

- Registered 1-to-4 and 1-to-8 demultiplexer pair driven by one shared data input and one shared 3-bit select.
- The 4-way path uses sel[1:0]; the 8-way path uses sel[2:0].
- Routes a data word to exactly one output lane; all other lanes are driven to zero.
- Used as a lane-steering primitive inside gate-level/Hack-style datapaths, with outputs registered for timing closure.

---
 rtl/dmux_pkg.sv | 16 +
 rtl/dmux_way_router_if.sv | 31 +++
 rtl/dmux_n_way.sv | 28 ++
 rtl/dmux_way_router.sv | 79 +++++++
 tb/tb_dmux_way_router.sv | 121 ++++++++++++
 5 files changed

// File: rtl/dmux_pkg.sv
// ============================================================================
// Module : dmux_pkg
// Brief  : Lane counts and select type shared by the dmux_way_router slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmux_pkg;
  localparam int LANES4 = 4;
  localparam int LANES8 = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

`default_nettype wire

// File: rtl/dmux_way_router_if.sv
// ============================================================================
// Module : dmux_way_router_if
// Brief  : Data, select, enable and lane outputs of dmux_way_router.
//          Status outputs exist only with DMUX_LANE_STATUS_EN defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmux_way_router_if #(
  parameter int WIDTH = 1
);
  import dmux_pkg::*;

  logic                      en;
  logic [WIDTH-1:0]          in;
  sel_t                      sel;
  logic [LANES4*WIDTH-1:0]   out4;
  logic [LANES8*WIDTH-1:0]   out8;
`ifdef DMUX_LANE_STATUS_EN
  logic [LANES4-1:0]         hit4;
  logic [LANES8-1:0]         hit8;

  modport master (output en, in, sel, input out4, out8, hit4, hit8);
  modport slave  (input en, in, sel, output out4, out8, hit4, hit8);
`else
  modport master (output en, in, sel, input out4, out8);
  modport slave  (input en, in, sel, output out4, out8);
`endif
endinterface

`default_nettype wire

// File: rtl/dmux_n_way.sv
// ============================================================================
// Module : dmux_n_way
// Brief  : Combinational 1-to-2**SEL_W demultiplexer; unselected lanes are 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmux_n_way #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 2
) (
  input  wire logic [WIDTH-1:0]               i_data,
  input  wire logic [SEL_W-1:0]               i_sel,
  output logic      [(1<<SEL_W)*WIDTH-1:0]    o_lanes
);
  localparam int LANES = 1 << SEL_W;

  always_comb begin
    o_lanes = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_lanes[k*WIDTH +: WIDTH] = i_data;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/dmux_way_router.sv
// ============================================================================
// Module : dmux_way_router
// Brief  : Registered 1-to-4 / 1-to-8 demux pair on a shared input and select.
//          Optional lane-hit status outputs: define DMUX_LANE_STATUS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmux_way_router #(
  parameter int WIDTH = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dmux_way_router_if.slave   bus
);
  import dmux_pkg::*;

  logic [LANES4*WIDTH-1:0] w_core4;
  logic [LANES8*WIDTH-1:0] w_core8;
  logic [LANES4*WIDTH-1:0] r_out4;
  logic [LANES8*WIDTH-1:0] r_out8;

  // The 4-way path deliberately drops sel[2].
  dmux_n_way #(.WIDTH(WIDTH), .SEL_W(2)) u_dmux4 (
    .i_data  (bus.in),
    .i_sel   (bus.sel[1:0]),
    .o_lanes (w_core4)
  );

  dmux_n_way #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dmux8 (
    .i_data  (bus.in),
    .i_sel   (bus.sel),
    .o_lanes (w_core8)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out4 <= '0;
      r_out8 <= '0;
    end else if (bus.en) begin
      r_out4 <= w_core4;
      r_out8 <= w_core8;
    end
  end

  assign bus.out4 = r_out4;
  assign bus.out8 = r_out8;

`ifdef DMUX_LANE_STATUS_EN
  logic [LANES4-1:0] w_hit4;
  logic [LANES8-1:0] w_hit8;
  logic [LANES4-1:0] r_hit4;
  logic [LANES8-1:0] r_hit8;

  // A lane is nonzero exactly when it is selected and in != 0.
  for (genvar k = 0; k < LANES4; k++) begin : g_hit4
    assign w_hit4[k] = |w_core4[k*WIDTH +: WIDTH];
  end

  for (genvar k = 0; k < LANES8; k++) begin : g_hit8
    assign w_hit8[k] = |w_core8[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit4 <= '0;
      r_hit8 <= '0;
    end else if (bus.en) begin
      r_hit4 <= w_hit4;
      r_hit8 <= w_hit8;
    end
  end

  assign bus.hit4 = r_hit4;
  assign bus.hit8 = r_hit8;
`endif
endmodule

`default_nettype wire

// File: tb/tb_dmux_way_router.sv
// ============================================================================
// Module : tb_dmux_way_router
// Brief  : Drives WIDTH=1 and WIDTH=8 routers in lockstep against a shift model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmux_way_router;
  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  dmux_way_router_if #(.WIDTH(1)) bus1 ();
  dmux_way_router_if #(.WIDTH(8)) bus8 ();

  dmux_way_router #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dmux_way_router #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected register contents
  logic [3:0]  m_out4_1;
  logic [7:0]  m_out8_1;
  logic [31:0] m_out4_8;
  logic [63:0] m_out8_8;
  logic [3:0]  m_hit4_1, m_hit4_8;
  logic [7:0]  m_hit8_1, m_hit8_8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic en_v, input logic in1_v,
                      input logic [7:0] in8_v, input int sel_v);
    int s4;
    @(negedge clk);
    rst_n    = rst_v;
    bus1.en  = en_v;
    bus8.en  = en_v;
    bus1.in  = in1_v;
    bus8.in  = in8_v;
    bus1.sel = 3'(sel_v);
    bus8.sel = 3'(sel_v);
    @(posedge clk);
    s4 = sel_v % 4;
    if (!rst_v) begin
      m_out4_1 = '0; m_out8_1 = '0; m_out4_8 = '0; m_out8_8 = '0;
      m_hit4_1 = '0; m_hit8_1 = '0; m_hit4_8 = '0; m_hit8_8 = '0;
    end else if (en_v) begin
      m_out4_1 = 4'(in1_v) << s4;
      m_out8_1 = 8'(in1_v) << sel_v;
      m_out4_8 = 32'(in8_v) << (8 * s4);
      m_out8_8 = 64'(in8_v) << (8 * sel_v);
      m_hit4_1 = (in1_v != 0)  ? (4'b1 << s4)    : 4'b0;
      m_hit8_1 = (in1_v != 0)  ? (8'b1 << sel_v) : 8'b0;
      m_hit4_8 = (in8_v != '0) ? (4'b1 << s4)    : 4'b0;
      m_hit8_8 = (in8_v != '0) ? (8'b1 << sel_v) : 8'b0;
    end
    #1;
    check("w1_out4", 64'(bus1.out4), 64'(m_out4_1));
    check("w1_out8", 64'(bus1.out8), 64'(m_out8_1));
    check("w8_out4", 64'(bus8.out4), 64'(m_out4_8));
    check("w8_out8", bus8.out8, m_out8_8);
`ifdef DMUX_LANE_STATUS_EN
    check("w1_hit4", 64'(bus1.hit4), 64'(m_hit4_1));
    check("w1_hit8", 64'(bus1.hit8), 64'(m_hit8_1));
    check("w8_hit4", 64'(bus8.hit4), 64'(m_hit4_8));
    check("w8_hit8", 64'(bus8.hit8), 64'(m_hit8_8));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.en = 1'b0; bus8.en = 1'b0;
    bus1.in = '0;   bus8.in = '0;
    bus1.sel = '0;  bus8.sel = '0;

    // Reset held for two edges with live data on the inputs
    step(1'b0, 1'b1, 1'b1, 8'hFF, 3);
    step(1'b0, 1'b1, 1'b1, 8'hFF, 3);

    // Zero data routes nowhere
    for (int s = 0; s < 8; s++) step(1'b1, 1'b1, 1'b0, 8'h00, s);

    // Walking lane with single-bit and byte-wide data
    for (int s = 0; s < 8; s++) step(1'b1, 1'b1, 1'b1, 8'hA5, s);

    // Hold while en is low and sel moves
    step(1'b1, 1'b1, 1'b1, 8'h3C, 2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'hC3, 6);
    step(1'b1, 1'b1, 1'b1, 8'hC3, 6);

    // Mid-run reset from lane h, then resume
    step(1'b1, 1'b1, 1'b1, 8'hA5, 7);
    step(1'b0, 1'b1, 1'b1, 8'hA5, 7);
    step(1'b1, 1'b1, 1'b1, 8'h5A, 1);
    step(1'b1, 1'b1, 1'b1, 8'h81, 4);

    // Reset has priority over a disabled enable too
    step(1'b1, 1'b1, 1'b1, 8'h77, 5);
    step(1'b0, 1'b0, 1'b1, 8'h77, 5);
    step(1'b1, 1'b0, 1'b1, 8'h77, 3);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(15) != 0), ($urandom_range(3) != 0),
           1'($urandom), 8'($urandom), int'($urandom_range(7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
